// File: rtl/saed32_mem_pkg.sv
// Shared constants, helper function and types for the tiled SAED32 2RW memory.
package saed32_mem_pkg;

   // Geometry of one SRAM2RW64X16 macro
   localparam int MACRO_W  = 16;
   localparam int MACRO_D  = 64;
   localparam int MACRO_AW = 6;

   // Per-cycle cross-port hazard flags
   typedef struct packed {
      logic ww_hit;   // both ports write the same word
      logic rw_hit0;  // port 0 reads the word port 1 is writing
      logic rw_hit1;  // port 1 reads the word port 0 is writing
   } collision_t;

   // Ceiling log2, usable in parameter expressions
   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v = value - 1;
      while (v > 0) begin
         result = result + 1;
         v = v >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/saed32_2rw_tile.sv
// One 64x16 two-port macro with active-high CE/WE and a per-bit write mask.
// The macro pins are active-low (CSB/WEB/OEB); this wrapper produces them.
module saed32_2rw_tile
   import saed32_mem_pkg::*;
(
   input  logic                clk,
   input  logic                rstn,
   input  logic                ce0,
   input  logic                we0,
   input  logic [MACRO_AW-1:0] a0,
   input  logic [MACRO_W-1:0]  d0,
   input  logic [MACRO_W-1:0]  wem0,
   output logic [MACRO_W-1:0]  q0,
   input  logic                ce1,
   input  logic                we1,
   input  logic [MACRO_AW-1:0] a1,
   input  logic [MACRO_W-1:0]  d1,
   input  logic [MACRO_W-1:0]  wem1,
   output logic [MACRO_W-1:0]  q1
);

   logic csb0, web0, oeb0;
   logic csb1, web1, oeb1;

   assign csb0 = ~ce0;
   assign web0 = ~(ce0 & we0);
   assign oeb0 = ~(ce0 & ~we0);
   assign csb1 = ~ce1;
   assign web1 = ~(ce1 & we1);
   assign oeb1 = ~(ce1 & ~we1);

   logic [MACRO_W-1:0] mem [MACRO_D];

   // Masked write with per-bit enables, so no read of the old word is needed.
   // Port 0 is applied last; the top already removes overlapping port 1 bits.
   always_ff @(posedge clk) begin
      if (!csb1 && !web1) begin
         for (int i = 0; i < MACRO_W; i++) begin
            if (wem1[i]) mem[a1][i] <= d1[i];
         end
      end
      if (!csb0 && !web0) begin
         for (int i = 0; i < MACRO_W; i++) begin
            if (wem0[i]) mem[a0][i] <= d0[i];
         end
      end
   end

   // Read ports: output latches the pre-write word and holds until the next read
   always_ff @(posedge clk) begin
      if (!rstn) begin
         q0 <= '0;
         q1 <= '0;
      end else begin
         if (!csb0 && !oeb0) q0 <= mem[a0];
         if (!csb1 && !oeb1) q1 <= mem[a1];
      end
   end

endmodule

// File: rtl/saed32_2rw_tiled_mem.sv
// True dual-port memory tiled from 64x16 macros: ROWS deep by COLS wide.
// Holds address decode, write/write arbitration, read-during-write bypass,
// output mux with hold, and the optional output register stage.
module saed32_2rw_tiled_mem
   import saed32_mem_pkg::*;
#(
   parameter  int WIDTH   = 32,
   parameter  int DEPTH   = 256,
   parameter  int OUT_REG = 0,
   localparam int AW      = clog2(DEPTH)
) (
   input  logic             CLK,
   input  logic             RSTN,
   input  logic             CE0,
   input  logic             WE0,
   input  logic [AW-1:0]    A0,
   input  logic [WIDTH-1:0] D0,
   input  logic [WIDTH-1:0] WEM0,
   output logic [WIDTH-1:0] Q0,
   input  logic             CE1,
   input  logic             WE1,
   input  logic [AW-1:0]    A1,
   input  logic [WIDTH-1:0] D1,
   input  logic [WIDTH-1:0] WEM1,
   output logic [WIDTH-1:0] Q1,
   output logic             COLL
);

   localparam int COLS = WIDTH / MACRO_W;
   localparam int ROWS = DEPTH / MACRO_D;
   localparam int RSEL = (ROWS > 1) ? clog2(ROWS) : 1;

   logic [RSEL-1:0]  row0, row1;
   logic             rd0, wr0, rd1, wr1;
   collision_t       hit;
   logic [WIDTH-1:0] wem1_eff;

   // Upper address bits pick the macro row; with a single row this is always 0
   assign row0 = RSEL'(A0 >> MACRO_AW);
   assign row1 = RSEL'(A1 >> MACRO_AW);

   // Accesses coincident with reset are dropped
   assign rd0 = RSTN & CE0 & ~WE0;
   assign wr0 = RSTN & CE0 & WE0;
   assign rd1 = RSTN & CE1 & ~WE1;
   assign wr1 = RSTN & CE1 & WE1;

   // Classify same-address cross-port hazards; port 0 owns contested bits
   always_comb begin
      hit         = '0;
      hit.ww_hit  = wr0 & wr1 & (A0 == A1);
      hit.rw_hit0 = rd0 & wr1 & (A0 == A1);
      hit.rw_hit1 = rd1 & wr0 & (A0 == A1);
      wem1_eff    = hit.ww_hit ? (WEM1 & ~WEM0) : WEM1;
   end

   logic [ROWS*WIDTH-1:0] tile_q0, tile_q1;

   for (genvar r = 0; r < ROWS; r++) begin : g_row
      logic sel0, sel1;
      assign sel0 = RSTN & CE0 & (row0 == RSEL'(r));
      assign sel1 = RSTN & CE1 & (row1 == RSEL'(r));
      for (genvar c = 0; c < COLS; c++) begin : g_col
         saed32_2rw_tile u_tile (
            .clk  (CLK),
            .rstn (RSTN),
            .ce0  (sel0),
            .we0  (WE0),
            .a0   (A0[MACRO_AW-1:0]),
            .d0   (D0[c*MACRO_W +: MACRO_W]),
            .wem0 (WEM0[c*MACRO_W +: MACRO_W]),
            .q0   (tile_q0[(r*COLS+c)*MACRO_W +: MACRO_W]),
            .ce1  (sel1),
            .we1  (WE1),
            .a1   (A1[MACRO_AW-1:0]),
            .d1   (D1[c*MACRO_W +: MACRO_W]),
            .wem1 (wem1_eff[c*MACRO_W +: MACRO_W]),
            .q1   (tile_q1[(r*COLS+c)*MACRO_W +: MACRO_W])
         );
      end
   end

   logic             rd_v0, rd_v1;
   logic [RSEL-1:0]  rd_row0, rd_row1;
   logic             byp_hit0, byp_hit1;
   logic [WIDTH-1:0] byp_d0, byp_m0, byp_d1, byp_m1;
   logic             coll_q;

   // Capture read row, bypass data/mask from the other port, and collision flag
   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         rd_v0    <= 1'b0;
         rd_v1    <= 1'b0;
         rd_row0  <= '0;
         rd_row1  <= '0;
         byp_hit0 <= 1'b0;
         byp_hit1 <= 1'b0;
         byp_d0   <= '0;
         byp_m0   <= '0;
         byp_d1   <= '0;
         byp_m1   <= '0;
         coll_q   <= 1'b0;
      end else begin
         rd_v0    <= rd0;
         rd_v1    <= rd1;
         rd_row0  <= row0;
         rd_row1  <= row1;
         byp_hit0 <= hit.rw_hit0;
         byp_hit1 <= hit.rw_hit1;
         byp_d0   <= D1;
         byp_m0   <= WEM1;
         byp_d1   <= D0;
         byp_m1   <= WEM0;
         coll_q   <= hit.ww_hit;
      end
   end

   logic [WIDTH-1:0] raw0, raw1, merged0, merged1, stage0, stage1;
   logic [WIDTH-1:0] hold0, hold1;

   // Select the read row, overlay bypassed bits, otherwise present the held word
   always_comb begin
      raw0    = tile_q0[rd_row0*WIDTH +: WIDTH];
      raw1    = tile_q1[rd_row1*WIDTH +: WIDTH];
      merged0 = byp_hit0 ? ((byp_d0 & byp_m0) | (raw0 & ~byp_m0)) : raw0;
      merged1 = byp_hit1 ? ((byp_d1 & byp_m1) | (raw1 & ~byp_m1)) : raw1;
      stage0  = rd_v0 ? merged0 : hold0;
      stage1  = rd_v1 ? merged1 : hold1;
   end

   // Hold register: last presented word, cleared by reset
   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         hold0 <= '0;
         hold1 <= '0;
      end else begin
         hold0 <= stage0;
         hold1 <= stage1;
      end
   end

   // With the output register enabled the hold register is itself that stage
   assign Q0   = (OUT_REG != 0) ? hold0 : stage0;
   assign Q1   = (OUT_REG != 0) ? hold1 : stage1;
   assign COLL = coll_q;

endmodule
